// File: rtl/bn_param_feeder.sv
// ============================================================================
// Module   : bn_param_feeder
// Purpose  : Loads per-channel BN (a, b) pairs. It then feeds them to the
//            BN unit, with param_a and param_b registered one stage apart.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bn_param_feeder #(
    parameter  int BN_DATA_WIDTH = 16,
    parameter  int CH_DEPTH      = 64,
    localparam int CH_AW         = $clog2(CH_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic [CH_AW:0]           cfg_num_ch,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [BN_DATA_WIDTH-1:0] ld_a,
    input  logic [BN_DATA_WIDTH-1:0] ld_b,
    input  logic                     req_valid,
    output logic [BN_DATA_WIDTH-1:0] param_a,
    output logic [BN_DATA_WIDTH-1:0] param_b,
    output logic                     loaded,
    output logic                     ch_wrap,
    output logic                     req_drop
);

    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_LOAD    = 2'd1;
    localparam logic [1:0]       S_SERVE   = 2'd2;
    localparam logic [CH_AW:0]   c_ONE     = (CH_AW+1)'(1);
    localparam logic [CH_AW:0]   c_MAX_CH  = (CH_AW+1)'(CH_DEPTH);
    localparam logic [CH_AW-1:0] c_PTR_ONE = CH_AW'(1);

    logic [1:0]                   r_state;
    logic [CH_AW:0]               r_num_ch;
    logic [CH_AW-1:0]             r_wr_ptr;
    logic [CH_AW-1:0]             r_rd_ch;
    logic                         r_ch_wrap;
    logic                         r_req_drop;
    logic [BN_DATA_WIDTH-1:0]     r_param_a;
    logic [BN_DATA_WIDTH-1:0]     r_b_stage;
    logic [BN_DATA_WIDTH-1:0]     r_param_b;
    logic                         r_b_vld;
    logic [2*BN_DATA_WIDTH-1:0]   r_mem [CH_DEPTH];

    logic w_cfg_legal;
    logic w_restart;
    logic w_ld_fire;
    logic w_serve;
    logic w_last_wr;
    logic w_last_rd;

    assign w_cfg_legal = cfg_start && (cfg_num_ch != '0) && (cfg_num_ch <= c_MAX_CH);
    assign w_restart   = w_cfg_legal && (r_state != S_LOAD);
    assign w_ld_fire   = ld_valid && (r_state == S_LOAD);
    assign w_serve     = req_valid && (r_state == S_SERVE);
    assign w_last_wr   = ({1'b0, r_wr_ptr} == (r_num_ch - c_ONE));
    assign w_last_rd   = ({1'b0, r_rd_ch} == (r_num_ch - c_ONE));

    // Handshake-facing flags are gated so they read low during reset immediately.
    assign ld_ready = rst_n && (r_state == S_LOAD);
    assign loaded   = rst_n && (r_state == S_SERVE);
    assign ch_wrap  = rst_n && r_ch_wrap;
    assign req_drop = rst_n && r_req_drop;
    assign param_a  = r_param_a;
    assign param_b  = r_param_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_num_ch   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ch    <= '0;
            r_ch_wrap  <= 1'b0;
            r_req_drop <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_SERVE: if (w_restart) r_state <= S_LOAD;
                S_LOAD:          if (w_ld_fire && w_last_wr) r_state <= S_SERVE;
                default:         r_state <= S_IDLE;
            endcase

            // A restart takes precedence over the read pointer advance of a
            // request served in the same cycle.
            if (w_restart) begin
                r_num_ch <= cfg_num_ch;
                r_wr_ptr <= '0;
                r_rd_ch  <= '0;
            end else begin
                if (w_ld_fire) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_serve)   r_rd_ch  <= w_last_rd ? '0 : r_rd_ch + c_PTR_ONE;
            end

            r_ch_wrap  <= w_serve && w_last_rd;
            r_req_drop <= req_valid && (r_state != S_SERVE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_fire) r_mem[r_wr_ptr] <= {ld_a, ld_b};
    end

    // The read port register is param_a itself; b takes one extra stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_param_a <= '0;
            r_b_stage <= '0;
            r_param_b <= '0;
            r_b_vld   <= 1'b0;
        end else begin
            r_b_vld <= w_serve;
            if (w_serve) {r_param_a, r_b_stage} <= r_mem[r_rd_ch];
            if (r_b_vld) r_param_b <= r_b_stage;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bn_param_feeder.sv
// ============================================================================
// Module   : tb_bn_param_feeder
// Purpose  : Directed bench for bn_param_feeder with a cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bn_param_feeder;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [6:0]    cfg_num_ch = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [W-1:0]  ld_a = '0;
    logic [W-1:0]  ld_b = '0;
    logic          req_valid = 1'b0;
    logic [W-1:0]  param_a;
    logic [W-1:0]  param_b;
    logic          loaded;
    logic          ch_wrap;
    logic          req_drop;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] da [64];
    logic [W-1:0] db [64];

    bn_param_feeder #(.BN_DATA_WIDTH(W), .CH_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_ch(cfg_num_ch),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
        .req_valid(req_valid), .param_a(param_a), .param_b(param_b),
        .loaded(loaded), .ch_wrap(ch_wrap), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: mode 0 idle, 1 loading, 2 serving.
    int           m_mode = 0;
    int           m_num = 0;
    int           m_wr = 0;
    int           m_rd = 0;
    logic [W-1:0] m_a [64];
    logic [W-1:0] m_b [64];
    logic [W-1:0] e_pa = '0;
    logic [W-1:0] e_pb = '0;
    logic [W-1:0] e_bpend = '0;
    bit           e_bv = 1'b0;
    bit           e_wrap = 1'b0;
    bit           e_drop = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_num = 0; m_wr = 0; m_rd = 0;
            e_pa = '0; e_pb = '0; e_bv = 1'b0; e_wrap = 1'b0; e_drop = 1'b0;
        end else begin
            bit legal;
            if (e_bv) e_pb = e_bpend;
            e_bv   = 1'b0;
            e_wrap = 1'b0;
            e_drop = 1'b0;
            if (req_valid) begin
                if (m_mode == 2) begin
                    e_pa    = m_a[m_rd];
                    e_bpend = m_b[m_rd];
                    e_bv    = 1'b1;
                    if (m_rd == m_num - 1) begin
                        e_wrap = 1'b1;
                        m_rd   = 0;
                    end else begin
                        m_rd++;
                    end
                end else begin
                    e_drop = 1'b1;
                end
            end
            legal = cfg_start && (int'(cfg_num_ch) >= 1) && (int'(cfg_num_ch) <= 64);
            if (m_mode == 1) begin
                if (ld_valid) begin
                    m_a[m_wr] = ld_a;
                    m_b[m_wr] = ld_b;
                    m_wr++;
                    if (m_wr == m_num) m_mode = 2;
                end
            end else if (legal) begin
                m_mode = 1;
                m_num  = int'(cfg_num_ch);
                m_wr   = 0;
                m_rd   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ld_ready", {31'd0, ld_ready}, {31'd0, rst_n && m_mode == 1});
            check("loaded",   {31'd0, loaded},   {31'd0, rst_n && m_mode == 2});
            check("ch_wrap",  {31'd0, ch_wrap},  {31'd0, rst_n && e_wrap});
            check("req_drop", {31'd0, req_drop}, {31'd0, rst_n && e_drop});
            check("param_a",  {16'd0, param_a},  {16'd0, e_pa});
            check("param_b",  {16'd0, param_b},  {16'd0, e_pb});
        end
    end

    task automatic load(input int n, input int stop_after, input bit do_start, input bit rnd);
        int  hs  = 0;
        int  cyc = 0;
        bit  fire;
        if (do_start) begin
            cfg_start  = 1'b1;
            cfg_num_ch = n[6:0];
            tick();
            cfg_start  = 1'b0;
        end
        while (hs < stop_after && cyc < 4000) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_a     = da[hs];
            ld_b     = db[hs];
            if (rnd && hs == 10) begin
                cfg_start  = 1'b1;
                cfg_num_ch = 7'd5;
            end
            fire = ld_valid && ld_ready;
            tick();
            cfg_start = 1'b0;
            if (fire) hs++;
            cyc++;
        end
        ld_valid = 1'b0;
        if (cyc >= 4000) check("load_timeout", 32'd1, 32'd0);
        if (stop_after == n) begin
            check("hs_count", hs, n);
            check("loaded_after_last", {31'd0, loaded}, 32'd1);
            check("ld_ready_drop", {31'd0, ld_ready}, 32'd0);
        end
    endtask

    task automatic requests(input int n);
        req_valid = 1'b1;
        repeat (n) tick();
        req_valid = 1'b0;
    endtask

    logic [W-1:0] pa [6];
    logic [W-1:0] pb [6];
    logic         wr [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_param_a",  {16'd0, param_a}, 32'd0);
        check("rst_param_b",  {16'd0, param_b}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_loaded",   {31'd0, loaded},   32'd0);
        rst_n = 1'b1;
        tick();

        // Illegal channel counts leave the block idle.
        cfg_start = 1'b1; cfg_num_ch = 7'd0;
        tick();
        cfg_start = 1'b0;
        check("illegal0_ld_ready", {31'd0, ld_ready}, 32'd0);
        cfg_start = 1'b1; cfg_num_ch = 7'd65;
        tick();
        cfg_start = 1'b0;
        check("illegal65_ld_ready", {31'd0, ld_ready}, 32'd0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("idle_req_drop", {31'd0, req_drop}, 32'd1);
        check("idle_param_a",  {16'd0, param_a}, 32'd0);
        check("idle_param_b",  {16'd0, param_b}, 32'd0);
        tick();
        check("idle_req_drop_pulse", {31'd0, req_drop}, 32'd0);

        // Basic load of three channels and four back-to-back requests.
        da[0] = 16'd1; da[1] = 16'd2; da[2] = 16'd3;
        db[0] = 16'd10; db[1] = 16'd20; db[2] = 16'hFFE2;
        load(3, 3, 1'b1, 1'b0);
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) req_valid = 1'b0;
            pa[i] = param_a;
            pb[i] = param_b;
            wr[i] = ch_wrap;
        end
        check("basic_pa1", {16'd0, pa[0]}, 32'd1);
        check("basic_pa2", {16'd0, pa[1]}, 32'd2);
        check("basic_pa3", {16'd0, pa[2]}, 32'd3);
        check("basic_pa4", {16'd0, pa[3]}, 32'd1);
        check("basic_pb2", {16'd0, pb[1]}, 32'd10);
        check("basic_pb3", {16'd0, pb[2]}, 32'd20);
        check("basic_pb4", {16'd0, pb[3]}, 32'h0000FFE2);
        check("basic_pb5", {16'd0, pb[4]}, 32'd10);
        check("basic_wrap_c2", {31'd0, wr[1]}, 32'd0);
        check("basic_wrap_c3", {31'd0, wr[2]}, 32'd1);
        check("basic_wrap_c4", {31'd0, wr[3]}, 32'd0);

        // Idle gaps between requests; channel 1 is next.
        requests(1);
        check("gap_pa", {16'd0, param_a}, 32'd2);
        tick();
        check("gap_pb", {16'd0, param_b}, 32'd20);
        tick(); tick();
        check("gap_hold_pa", {16'd0, param_a}, 32'd2);
        check("gap_hold_pb", {16'd0, param_b}, 32'd20);
        requests(1);
        check("gap2_pa", {16'd0, param_a}, 32'd3);
        repeat (3) tick();
        requests(2);
        tick();

        // Reload from channel 2 with a simultaneous request.
        cfg_start = 1'b1; cfg_num_ch = 7'd2; req_valid = 1'b1;
        tick();
        cfg_start = 1'b0; req_valid = 1'b0;
        check("reload_pa", {16'd0, param_a}, 32'd3);
        check("reload_ld_ready", {31'd0, ld_ready}, 32'd1);
        da[0] = 16'd7; da[1] = 16'd8;
        db[0] = 16'd70; db[1] = 16'd80;
        load(2, 2, 1'b0, 1'b0);
        requests(1);
        check("reload_ch0_pa", {16'd0, param_a}, 32'd7);
        tick();
        check("reload_ch0_pb", {16'd0, param_b}, 32'd70);
        requests(3);
        repeat (2) tick();

        // Full-depth load with random backpressure.
        for (int i = 0; i < 64; i++) begin
            da[i] = W'($urandom);
            db[i] = W'($urandom);
        end
        load(64, 64, 1'b1, 1'b1);
        requests(66);
        repeat (2) tick();

        // Reset in the middle of a load, then a normal load of eight.
        for (int i = 0; i < 8; i++) begin
            da[i] = W'(16'h100 + i);
            db[i] = W'(16'h8000 + i);
        end
        load(8, 5, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_param_a",  {16'd0, param_a}, 32'd0);
        check("mid_rst_param_b",  {16'd0, param_b}, 32'd0);
        check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("mid_rst_loaded",   {31'd0, loaded},   32'd0);
        check("mid_rst_ch_wrap",  {31'd0, ch_wrap},  32'd0);
        check("mid_rst_req_drop", {31'd0, req_drop}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, ld_ready}, 32'd0);
        load(8, 8, 1'b1, 1'b0);
        requests(1);
        check("post_rst_pa0", {16'd0, param_a}, 32'h100);
        requests(8);
        check("post_rst_pa_wrap", {16'd0, param_a}, 32'h100);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bn_param_feeder.md
BN_PARAM_FEEDER -- requirements
Module: bn_param_feeder

Interface
REQ-001 SHALL have parameter BN_DATA_WIDTH, default 16, width of each BN parameter word.
REQ-002 SHALL have parameter CH_DEPTH, default 64, maximum number of output channels stored; CH_AW = clog2(CH_DEPTH).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_start  input  1  single-cycle pulse that starts a parameter load.
REQ-006 SHALL have port cfg_num_ch  input  CH_AW+1  channel count for the layer, sampled on accepted cfg_start, legal 1..CH_DEPTH.
REQ-007 SHALL have port ld_valid / ld_ready  input / output  1 / 1  load-stream handshake.
REQ-008 SHALL have port ld_a, ld_b  input  BN_DATA_WIDTH each  signed parameter pair for the next channel.
REQ-009 SHALL have port req_valid  input  1  compute-side request, asserted one cycle before the BN unit's result-valid.
REQ-010 SHALL have port param_a, param_b  output  BN_DATA_WIDTH each  signed parameters toward the BN unit.
REQ-011 SHALL have port loaded  output  1  high while in SERVE.
REQ-012 SHALL have port ch_wrap  output  1  pulse when the served channel index wraps to 0.
REQ-013 SHALL have port req_drop  output  1  pulse when req_valid arrives outside SERVE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SERVE.
REQ-015 SHALL leave IDLE for LOAD on cfg_start with 1 <= cfg_num_ch <= CH_DEPTH; otherwise SHALL stay in IDLE.
REQ-016 SHALL latch cfg_num_ch into num_ch and clear wr_ptr and rd_ch on entry to LOAD.
REQ-017 SHALL drive ld_ready = 1 only in LOAD, combinationally from state.
REQ-018 SHALL, on each ld_valid & ld_ready cycle, write ld_a/ld_b to storage at wr_ptr and increment wr_ptr.
REQ-019 SHALL go from LOAD to SERVE on the cycle after the handshake with wr_ptr = num_ch-1; storage of that pair SHALL complete in that same cycle.
REQ-020 SHALL ignore cfg_start while in LOAD.
REQ-021 SHALL, in SERVE, restart a load (go to LOAD, re-latch cfg_num_ch) on a legal cfg_start; a req_valid in that same cycle SHALL still be served.
REQ-022 SHALL, in SERVE on req_valid, register storage[rd_ch].a into param_a at the next edge (valid in the same cycle as the BN unit's result-valid).
REQ-023 SHALL register storage[rd_ch].b through two stages, so param_b updates one cycle after param_a (aligned to the BN unit's multiply stage).
REQ-024 SHALL increment rd_ch on each served req_valid; from num_ch-1 it SHALL wrap to 0 and pulse ch_wrap for one cycle, in the cycle param_a is updated.
REQ-025 SHALL hold param_a/param_b when no request is served; back-to-back req_valid SHALL be served every cycle.
REQ-026 SHALL ignore req_valid outside SERVE: no output or rd_ch change, and req_drop pulses the following cycle.
REQ-027 SHALL treat parameter data as opaque bits, with no arithmetic or sign change.
REQ-028 SHALL implement storage as a synchronous-read RAM, CH_DEPTH x 2*BN_DATA_WIDTH, one write port and one read port.

Reset
REQ-029 SHALL, while rst_n = 0, force state IDLE, wr_ptr = rd_ch = num_ch = 0, and param_a = param_b = 0.
REQ-030 SHALL, while rst_n = 0, force ld_ready = loaded = ch_wrap = req_drop = 0.
REQ-031 SHALL abandon a load on reset mid-LOAD; storage contents need not be cleared, and a new cfg_start is required.

Verification
REQ-032 SHALL cover basic load/serve: cfg_num_ch = 3, load pairs (1,10),(2,20),(3,-30), then 4 consecutive req_valid -> param_a = 1,2,3,1 on cycles +1..+4; param_b = 10,20,-30,10 on cycles +2..+5; ch_wrap high on cycle +3.
REQ-033 SHALL cover load backpressure: ld_valid toggled randomly with cfg_num_ch = 64 -> exactly 64 pairs accepted, loaded rises the cycle after the 64th handshake, and ld_ready then drops.
REQ-034 SHALL cover illegal start: cfg_start with cfg_num_ch = 0 or 65 -> stays IDLE, ld_ready = 0; req_valid there -> req_drop pulse, param_a/param_b stay 0.
REQ-035 SHALL cover reload: in SERVE with rd_ch = 2, cfg_start with cfg_num_ch = 2 plus simultaneous req_valid -> that request is served, then LOAD with rd_ch = 0; the new pairs are served from channel 0.
REQ-036 SHALL cover reset mid-load: rst_n low after 5 of 8 pairs -> all outputs 0, IDLE; a subsequent full load of 8 operates normally.
REQ-037 SHALL cover idle gaps: requests separated by 3 idle cycles -> param_a/param_b hold their values between requests.
